// File: rtl/crank_cam_gen.sv
// Crank/cam wheel simulator: a 60-2 style VR square wave, tooth and revolution strobes,
// a per-tooth signed period ramp with saturation, and a two-revolution cam window.
module crank_cam_gen #(
  parameter int TOOTH_NUM = 60,
  parameter int MISSING   = 2,
  parameter int PW        = 16,
  parameter int IW        = $clog2(TOOTH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PW-1:0]        period_init,
  input  logic signed [PW-1:0] period_step,
  input  logic [PW-1:0]        period_min,
  input  logic [IW-1:0]        cam_lo_start,
  input  logic [IW-1:0]        cam_lo_end,
  output logic                 vr,
  output logic                 cam,
  output logic                 cam_phase,
  output logic [IW-1:0]        tooth_idx,
  output logic                 tooth_stb,
  output logic                 rev_stb,
  output logic [PW-1:0]        period
);

  localparam int            LW       = PW + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOOTH_NUM - MISSING - 1);
  localparam logic [PW-1:0] PMAX     = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               en_q;
  logic [LW-1:0]      cnt;

  logic               start;
  logic               run_boundary;
  logic               wrap;
  logic [LW-1:0]      len_cur;
  logic [LW-1:0]      len_nxt;
  logic [LW-1:0]      cnt_nxt;
  logic [IW-1:0]      idx_nxt;
  logic [PW-1:0]      per_nxt;
  logic [PW-1:0]      per_load;
  logic [PW-1:0]      per_stepped;
  logic               phase_nxt;
  logic signed [LW-1:0] sum;
  logic signed [LW-1:0] pmin_s;
  logic signed [LW-1:0] pmax_s;

  // The gap tooth spans the missing positions plus itself.
  function automatic logic [LW-1:0] tooth_len(input logic [IW-1:0] idx, input logic [PW-1:0] p);
    if (idx == LAST_IDX)
      return LW'(MISSING + 1) * {2'b00, p};
    else
      return {2'b00, p};
  endfunction

  function automatic logic cam_val(input logic [IW-1:0] idx, input logic ph);
    return !(ph && (cam_lo_start < cam_lo_end) &&
             (idx >= cam_lo_start) && (idx < cam_lo_end));
  endfunction

  assign start        = (state == IDLE) && en && !en_q;
  assign len_cur      = tooth_len(tooth_idx, period);
  assign run_boundary = (state == RUN) && (cnt == len_cur - LW'(1));
  assign wrap         = (tooth_idx == LAST_IDX);
  assign per_load     = (period_init < period_min) ? period_min : period_init;

  // Two guard bits keep the signed sum free of overflow before clamping.
  assign sum    = $signed({2'b00, period}) + $signed({{2{period_step[PW-1]}}, period_step});
  assign pmin_s = $signed({2'b00, period_min});
  assign pmax_s = $signed({2'b00, PMAX});

  always_comb begin
    per_stepped = sum[PW-1:0];
    if (sum < pmin_s)
      per_stepped = period_min;
    else if (sum > pmax_s)
      per_stepped = PMAX;
  end

  always_comb begin
    cnt_nxt   = '0;
    idx_nxt   = tooth_idx;
    per_nxt   = period;
    phase_nxt = cam_phase;
    if (start) begin
      idx_nxt   = '0;
      per_nxt   = per_load;
      phase_nxt = 1'b0;
    end else if (run_boundary) begin
      idx_nxt   = wrap ? '0 : tooth_idx + IW'(1);
      per_nxt   = per_stepped;
      phase_nxt = cam_phase ^ wrap;
    end else if (state == RUN) begin
      cnt_nxt   = cnt + LW'(1);
    end
    len_nxt = tooth_len(idx_nxt, per_nxt);
  end

  // en_q resets high so an en level held through reset is not taken as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      en_q      <= 1'b1;
      cnt       <= '0;
      tooth_idx <= '0;
      period    <= '0;
      cam_phase <= 1'b0;
      vr        <= 1'b0;
      cam       <= 1'b1;
      tooth_stb <= 1'b0;
      rev_stb   <= 1'b0;
    end else begin
      en_q <= en;
      if (start || ((state == RUN) && en)) begin
        state     <= RUN;
        cnt       <= cnt_nxt;
        tooth_idx <= idx_nxt;
        period    <= per_nxt;
        cam_phase <= phase_nxt;
        vr        <= (cnt_nxt >= (len_nxt >> 1));
        cam       <= cam_val(idx_nxt, phase_nxt);
        tooth_stb <= start || run_boundary;
        rev_stb   <= start || (run_boundary && wrap);
      end else begin
        state     <= IDLE;
        cnt       <= '0;
        vr        <= 1'b0;
        cam       <= 1'b1;
        tooth_stb <= 1'b0;
        rev_stb   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crank_cam_gen.sv
// Scoreboard bench for crank_cam_gen: stimulus queues expected teeth, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_crank_cam_gen;

  localparam int LAST  = 57;
  localparam int TEETH = 58;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] period_init = 16'd0;
  logic [15:0] period_step = 16'd0;
  logic [15:0] period_min  = 16'd2;
  logic [5:0]  cam_lo_start = 6'd0;
  logic [5:0]  cam_lo_end   = 6'd0;
  logic        vr, cam, cam_phase, tooth_stb, rev_stb;
  logic [5:0]  tooth_idx;
  logic [15:0] period;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  crank_cam_gen dut (
    .clk(clk), .rst(rst), .en(en),
    .period_init(period_init), .period_step(period_step), .period_min(period_min),
    .cam_lo_start(cam_lo_start), .cam_lo_end(cam_lo_end),
    .vr(vr), .cam(cam), .cam_phase(cam_phase), .tooth_idx(tooth_idx),
    .tooth_stb(tooth_stb), .rev_stb(rev_stb), .period(period)
  );

  typedef struct {
    int idx;
    int per;
    bit rev;
    bit phase;
    bit cam;
    bit chk_len;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 0;
  int   k = 0;
  int   rise = -1;
  bit   fell = 0;
  int   elen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_tooth(input int idx, input int per, input bit phase,
                            input int lo, input int hi, input bit chk);
    exp_t e;
    e.idx     = idx;
    e.per     = per;
    e.rev     = (idx == 0);
    e.phase   = phase;
    e.cam     = !(phase && (lo < hi) && (lo <= idx) && (idx < hi));
    e.chk_len = chk;
    q.push_back(e);
  endtask

  // Constant-period run starting at tooth 0 of an even revolution.
  task automatic push_revs(input int n, input int per, input int lo, input int hi);
    for (int i = 0; i < n; i++)
      push_tooth(i % TEETH, per, bit'((i / TEETH) % 2), lo, hi, i != n - 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      have_cur = 0;
    end else begin
      if (rev_stb && !tooth_stb) begin
        tests++;
        fails++;
        $display("FAIL rev_without_tooth: got rev_stb=1 tooth_stb=0 expected tooth_stb=1");
      end
      if (tooth_stb) begin
        if (have_cur && cur.chk_len) begin
          elen = (cur.idx == LAST) ? 3 * cur.per : cur.per;
          check($sformatf("len_t%0d_p%0d", cur.idx, cur.per), k + 1, elen);
          check($sformatf("vr_rise_t%0d", cur.idx), rise, elen / 2);
          check($sformatf("vr_stable_t%0d", cur.idx), {31'd0, fell}, 0);
        end
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got tooth_stb at idx %0d expected none", tooth_idx);
          have_cur = 0;
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          check($sformatf("idx_t%0d", cur.idx), tooth_idx, cur.idx);
          check($sformatf("period_t%0d", cur.idx), period, cur.per);
          check($sformatf("rev_stb_t%0d", cur.idx), rev_stb, cur.rev);
          check($sformatf("phase_t%0d", cur.idx), cam_phase, cur.phase);
          check($sformatf("cam_t%0d", cur.idx), cam, cur.cam);
          check($sformatf("vr_start_t%0d", cur.idx), vr, 0);
        end
        k = 0;
        rise = -1;
        fell = 0;
      end else if (have_cur) begin
        k++;
        if (vr && rise < 0) rise = k;
        if (!vr && rise >= 0) fell = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int init, input int step, input int pmin, input int lo, input int hi);
    period_init  = 16'(init);
    period_step  = 16'(step);
    period_min   = 16'(pmin);
    cam_lo_start = 6'(lo);
    cam_lo_end   = 6'(hi);
    en = 1'b0;
    tick(2);
    en = 1'b1;
  endtask

  task automatic wait_q(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d teeth pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic drain_and_stop(input int budget);
    wait_q(budget);
    tick(1);
    en = 1'b0;
    tick(2);
  endtask

  task automatic print_summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time limit");
    fails++;
    print_summary();
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_vr", vr, 0);
    check("rst_cam", cam, 1);
    check("rst_phase", cam_phase, 0);
    check("rst_idx", tooth_idx, 0);
    check("rst_period", period, 0);
    check("rst_tooth_stb", tooth_stb, 0);
    check("rst_rev_stb", rev_stb, 0);
    rst = 1'b0;
    tick(2);

    // Default wheel, one full revolution plus the next tooth 0.
    push_revs(59, 64, 4, 54);
    start(64, 0, 2, 4, 54);
    drain_and_stop(5000);

    // Cam window over two revolutions, then an empty window.
    push_revs(117, 4, 4, 54);
    start(4, 0, 2, 4, 54);
    drain_and_stop(1000);
    push_revs(117, 4, 54, 4);
    start(4, 0, 2, 54, 4);
    drain_and_stop(1000);

    // Positive ramp.
    push_tooth(0, 16, 0, 4, 54, 1);
    push_tooth(1, 17, 0, 4, 54, 1);
    push_tooth(2, 18, 0, 4, 54, 1);
    push_tooth(3, 19, 0, 4, 54, 0);
    start(16, 1, 2, 4, 54);
    drain_and_stop(200);

    // Negative ramp clamped at period_min.
    push_tooth(0, 20, 0, 4, 54, 1);
    push_tooth(1, 16, 0, 4, 54, 1);
    push_tooth(2, 16, 0, 4, 54, 1);
    push_tooth(3, 16, 0, 4, 54, 0);
    start(20, -10, 16, 4, 54);
    drain_and_stop(200);

    // period_init below period_min loads period_min.
    push_tooth(0, 6, 0, 4, 54, 1);
    push_tooth(1, 6, 0, 4, 54, 0);
    start(3, 0, 6, 4, 54);
    drain_and_stop(100);

    // Upper saturation.
    push_tooth(0, 65534, 0, 4, 54, 1);
    push_tooth(1, 65535, 0, 4, 54, 0);
    start(65534, 5, 2, 4, 54);
    drain_and_stop(70000);

    // Asynchronous reset at cnt=20 of tooth 2.
    push_tooth(0, 32, 0, 4, 54, 1);
    push_tooth(1, 32, 0, 4, 54, 1);
    push_tooth(2, 32, 0, 4, 54, 0);
    start(32, 0, 2, 4, 54);
    wait_q(200);
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_vr", vr, 0);
    check("midrst_cam", cam, 1);
    check("midrst_phase", cam_phase, 0);
    check("midrst_idx", tooth_idx, 0);
    check("midrst_period", period, 0);
    check("midrst_tooth_stb", tooth_stb, 0);
    check("midrst_rev_stb", rev_stb, 0);
    tick(3);
    rst = 1'b0;
    tick(10);
    check("held_en_vr", vr, 0);
    check("held_en_tooth_stb", tooth_stb, 0);
    check("held_en_period", period, 0);
    push_tooth(0, 32, 0, 4, 54, 1);
    push_tooth(1, 32, 0, 4, 54, 0);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    drain_and_stop(200);

    // Drop en during tooth 30, then restart with a new period.
    push_revs(31, 8, 4, 54);
    start(8, 0, 2, 4, 54);
    wait_q(1000);
    tick(1);
    en = 1'b0;
    tick(1);
    check("drop_vr", vr, 0);
    check("drop_cam", cam, 1);
    check("drop_tooth_stb", tooth_stb, 0);
    check("drop_rev_stb", rev_stb, 0);
    check("drop_idx", tooth_idx, 30);
    check("drop_period", period, 8);
    tick(5);
    check("idle_idx_hold", tooth_idx, 30);
    check("idle_period_hold", period, 8);
    check("idle_phase_hold", cam_phase, 0);
    push_tooth(0, 12, 0, 4, 54, 1);
    push_tooth(1, 12, 0, 4, 54, 0);
    start(12, 0, 2, 4, 54);
    drain_and_stop(200);

    check("queue_empty", q.size(), 0);
    print_summary();
    $finish;
  end

endmodule
